// File: rtl/vote_arbiter_ctrl.sv
// Round-robin vote arbiter with tick-timed lockout and release wait.
// Shares saturating per-candidate counters between N_CAND buttons.
module vote_arbiter_ctrl #(
  parameter  int N_CAND     = 4,
  parameter  int CNT_W      = 8,
  parameter  int TICK_DIV   = 25_000_000,
  parameter  int LOCK_TICKS = 4,
  localparam int IDX_W      = (N_CAND > 1) ? $clog2(N_CAND) : 1
) (
  input  logic                    clk_100MHz,
  input  logic                    reset_n,
  input  logic [N_CAND-1:0]       btn_req,
  input  logic                    clear,
  output logic                    vote_valid,
  output logic [IDX_W-1:0]        vote_idx,
  output logic [N_CAND*CNT_W-1:0] counts,
  output logic                    busy,
  output logic                    led_blink
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOCK,
    WAIT_REL
  } state_t;

  state_t                         state_q, state_d;
  logic [N_CAND-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic                           valid_q, valid_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [IDX_W-1:0]               rr_q, rr_d;
  logic [TW-1:0]                  tick_q, tick_d;
  logic [LW-1:0]                  lock_q, lock_d;
  logic                           led_q, led_d;
  logic [IDX_W-1:0]               grant;
  logic                           any_req;
  logic                           tick;
  logic                           last_lock;

  function automatic logic [IDX_W-1:0] rr_add(
    input logic [IDX_W-1:0] b,
    input int               k
  );
    logic [IDX_W:0] s;
    s = {1'b0, b} + (IDX_W+1)'(k);
    if (s >= (IDX_W+1)'(N_CAND))
      s = s - (IDX_W+1)'(N_CAND);
    return s[IDX_W-1:0];
  endfunction

  assign any_req   = |btn_req;
  assign tick      = (tick_q == TW'(TICK_DIV - 1));
  assign last_lock = (lock_q == LW'(LOCK_TICKS - 1));

  // Descending scan so the last hit is the first set bit from rr_q.
  always_comb begin
    grant = '0;
    for (int k = N_CAND - 1; k >= 0; k--) begin
      if (btn_req[rr_add(rr_q, k)])
        grant = rr_add(rr_q, k);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    idx_d   = idx_q;
    rr_d    = rr_q;
    tick_d  = tick ? '0 : tick_q + 1'b1;
    lock_d  = lock_q;
    led_d   = led_q;
    if (clear) begin
      cnt_d   = '0;
      rr_d    = '0;
      led_d   = 1'b0;
      state_d = WAIT_REL;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            if (cnt_q[grant] != '1)
              cnt_d[grant] = cnt_q[grant] + 1'b1;
            valid_d = 1'b1;
            idx_d   = grant;
            rr_d    = rr_add(grant, 1);
            tick_d  = '0;
            lock_d  = '0;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (tick) begin
            if (last_lock) begin
              state_d = WAIT_REL;
              led_d   = 1'b0;
            end else begin
              led_d  = ~led_q;
              lock_d = lock_q + 1'b1;
            end
          end
        end
        WAIT_REL: begin
          if (!any_req)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      rr_q    <= '0;
      tick_q  <= '0;
      lock_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      tick_q  <= tick_d;
      lock_q  <= lock_d;
      led_q   <= led_d;
    end
  end

  assign vote_valid = valid_q;
  assign vote_idx   = idx_q;
  assign counts     = cnt_q;
  assign busy       = (state_q != IDLE);
  assign led_blink  = led_q;

endmodule

// File: tb/tb_vote_arbiter_ctrl.sv
// Scoreboard bench for vote_arbiter_ctrl.
// Expected votes are queued at press time and checked on vote_valid.
module tb_vote_arbiter_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TD = 4;
  localparam int LT = 2;

  logic           clk_100MHz = 1'b0;
  logic           reset_n;
  logic [N-1:0]   btn_req;
  logic           clear;
  logic           vote_valid;
  logic [1:0]     vote_idx;
  logic [N*W-1:0] counts;
  logic           busy;
  logic           led_blink;

  typedef struct {
    int idx;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   mc[N];
  int   n_cmp = 0;
  int   n_err = 0;

  vote_arbiter_ctrl #(
    .N_CAND    (N),
    .CNT_W     (W),
    .TICK_DIV  (TD),
    .LOCK_TICKS(LT)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset_n   (reset_n),
    .btn_req   (btn_req),
    .clear     (clear),
    .vote_valid(vote_valid),
    .vote_idx  (vote_idx),
    .counts    (counts),
    .busy      (busy),
    .led_blink (led_blink)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] model_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*W +: W] = W'(mc[i]);
    return v;
  endfunction

  task automatic push(input int idx);
    exp_t e;
    if (mc[idx] < 255)
      mc[idx]++;
    e.idx = idx;
    e.cnt = mc[idx];
    exp_q.push_back(e);
  endtask

  task automatic zero_model();
    for (int i = 0; i < N; i++)
      mc[i] = 0;
  endtask

  always @(negedge clk_100MHz) begin
    if (reset_n && vote_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexp_vote", 32'(vote_idx), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("vote_idx", 32'(vote_idx), 32'(e.idx));
        chk("vote_cnt", 32'(counts[e.idx*W +: W]), 32'(e.cnt));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk_100MHz);
      n++;
    end
    chk("idle", 32'(busy), 0);
  endtask

  task automatic vote(input logic [N-1:0] m, input int idx);
    btn_req = m;
    push(idx);
    @(negedge clk_100MHz);
    btn_req = '0;
    wait_idle();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk_100MHz);
    clear = 1'b0;
    zero_model();
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    btn_req = '0;
    clear   = 1'b0;
    zero_model();
    repeat (2) @(negedge clk_100MHz);
    chk("rst_valid", 32'(vote_valid), 0);
    chk("rst_idx", 32'(vote_idx), 0);
    chk("rst_counts", counts, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_led", 32'(led_blink), 0);
    reset_n = 1'b1;
    @(negedge clk_100MHz);

    // 1: held press votes once, 8 LOCK cycles, then WAIT_REL -> IDLE
    btn_req = 4'b0010;
    push(1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_100MHz);
      chk($sformatf("t1_busy%0d", k), 32'(busy), 32'(k <= 9));
      chk($sformatf("t1_led%0d", k), 32'(led_blink),
          32'(k >= 5 && k <= 8));
      if (k == 3)
        btn_req = '0;
    end
    chk("t1_counts", counts, model_vec());

    // 2: round robin from a cleared pointer, then wrap
    do_clear();
    chk("t2_clr", counts, 0);
    for (int g = 0; g < N; g++)
      vote(4'b1111, g);
    chk("t2_counts", counts, 32'h0101_0101);
    vote(4'b1111, 0);
    chk("t2_wrap", counts, model_vec());

    // 3: press during LOCK is ignored
    btn_req = 4'b1000;
    push(3);
    @(negedge clk_100MHz);
    btn_req = '0;
    repeat (2) @(negedge clk_100MHz);
    btn_req = 4'b0001;
    @(negedge clk_100MHz);
    btn_req = '0;
    wait_idle();
    chk("t3_counts", counts, model_vec());

    // 4: saturation
    do_clear();
    for (int i = 0; i < 256; i++)
      vote(4'b0100, 2);
    chk("t4_sat", 32'(counts[2*W +: W]), 255);
    chk("t4_counts", counts, model_vec());

    // 5: clear with a request in IDLE
    btn_req = 4'b0100;
    clear   = 1'b1;
    zero_model();
    @(negedge clk_100MHz);
    clear = 1'b0;
    chk("t5_counts", counts, 0);
    chk("t5_busy", 32'(busy), 1);
    repeat (12) @(negedge clk_100MHz);
    chk("t5_hold", 32'(busy), 1);
    btn_req = '0;
    @(negedge clk_100MHz);
    chk("t5_idle", 32'(busy), 0);

    // 6: async reset mid-LOCK
    btn_req = 4'b0010;
    push(1);
    @(negedge clk_100MHz);
    btn_req = '0;
    repeat (3) @(negedge clk_100MHz);
    #2;
    reset_n = 1'b0;
    #1;
    zero_model();
    chk("t6_valid", 32'(vote_valid), 0);
    chk("t6_idx", 32'(vote_idx), 0);
    chk("t6_counts", counts, 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_led", 32'(led_blink), 0);
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    @(negedge clk_100MHz);
    vote(4'b1100, 2);
    chk("t6_counts2", counts, model_vec());

    repeat (3) @(negedge clk_100MHz);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
